// File: rtl/target_box_detect.sv
// Colour-threshold target tracker: per-frame bounding box, centre and match count, with 2-clk video pass-through.
// Pack layout (MSB..LSB): {r[7:0], g[7:0], b[7:0], hsync, vsync, de, spare, x[XW-1:0], y[YW-1:0]}. Optional border overlay: TARGET_BOX_OVERLAY_EN.
module target_box_detect #(
    parameter int H_ACT      = 1280,
    parameter int V_ACT      = 720,
    parameter int MIN_PIXELS = 64,
`ifdef TARGET_BOX_OVERLAY_EN
    parameter logic [23:0] OVERLAY_COLOR = 24'h00FF00,
`endif
    localparam int XW = $clog2(H_ACT),
    localparam int YW = $clog2(V_ACT),
    localparam int PW = 3*8 + 4 + XW + YW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PW-1:0]     i_pack,
    input  logic              en,
    input  logic [7:0]        thr_r_min,
    input  logic [7:0]        thr_g_max,
    input  logic [7:0]        thr_b_max,
    output logic [PW-1:0]     o_pack,
    output logic [XW-1:0]     box_x0,
    output logic [XW-1:0]     box_x1,
    output logic [YW-1:0]     box_y0,
    output logic [YW-1:0]     box_y1,
    output logic [XW-1:0]     box_cx,
    output logic [YW-1:0]     box_cy,
    output logic [XW+YW-1:0]  box_cnt,
    output logic              box_valid,
    output logic              frame_done
);

    localparam int CW    = XW + YW;
    localparam int DE_B  = XW + YW + 1;
    localparam int VS_B  = XW + YW + 2;
    localparam int RGB_L = XW + YW + 4;
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

    typedef enum logic {S_DISARMED, S_ARMED} state_t;

    logic [7:0]    w_r, w_g, w_b;
    logic          w_vs, w_de;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic          w_edge, w_match, w_publish;
    logic [XW:0]   w_sum_x;
    logic [YW:0]   w_sum_y;
    logic [PW-1:0] w_pack_s2;

    state_t        r_state, w_state_nxt;
    logic          r_vsync_d;
    logic [XW-1:0] r_min_x, r_max_x;
    logic [YW-1:0] r_min_y, r_max_y;
    logic [CW-1:0] r_cnt;
    logic [XW-1:0] r_box_x0, r_box_x1, r_box_cx;
    logic [YW-1:0] r_box_y0, r_box_y1, r_box_cy;
    logic [CW-1:0] r_box_cnt;
    logic          r_box_valid, r_frame_done;
    logic [PW-1:0] r_pack_d1, r_pack_d2;

    assign w_r  = i_pack[RGB_L+16 +: 8];
    assign w_g  = i_pack[RGB_L+8 +: 8];
    assign w_b  = i_pack[RGB_L +: 8];
    assign w_vs = i_pack[VS_B];
    assign w_de = i_pack[DE_B];
    assign w_x  = i_pack[YW +: XW];
    assign w_y  = i_pack[0 +: YW];

    assign w_edge  = w_vs & ~r_vsync_d;
    assign w_match = w_de && (w_r >= thr_r_min) && (w_g <= thr_g_max) && (w_b <= thr_b_max);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_vsync_d <= 1'b0;
        else     r_vsync_d <= w_vs;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_DISARMED;
        else     r_state <= w_state_nxt;
    end

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_DISARMED: if (w_edge) w_state_nxt = S_ARMED;
            S_ARMED:    w_state_nxt = S_ARMED;
            default:    w_state_nxt = S_DISARMED;
        endcase
    end

    always_comb begin
        w_publish = 1'b0;
        if (r_state == S_ARMED) w_publish = w_edge & en;
    end

    // The edge cycle clears and never accumulates, so its pixel cannot leak into either frame.
    always_ff @(posedge clk) begin
        if (rst || w_edge) begin
            r_min_x <= '1;
            r_max_x <= '0;
            r_min_y <= '1;
            r_max_y <= '0;
            r_cnt   <= '0;
        end else if (w_match) begin
            if (w_x < r_min_x) r_min_x <= w_x;
            if (w_x > r_max_x) r_max_x <= w_x;
            if (w_y < r_min_y) r_min_y <= w_y;
            if (w_y > r_max_y) r_max_y <= w_y;
            if (r_cnt != '1)   r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign w_sum_x = {1'b0, r_min_x} + {1'b0, r_max_x};
    assign w_sum_y = {1'b0, r_min_y} + {1'b0, r_max_y};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_box_x0     <= '0;
            r_box_x1     <= '0;
            r_box_y0     <= '0;
            r_box_y1     <= '0;
            r_box_cx     <= '0;
            r_box_cy     <= '0;
            r_box_cnt    <= '0;
            r_box_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_publish;
            if (w_publish) begin
                r_box_x0    <= r_min_x;
                r_box_x1    <= r_max_x;
                r_box_y0    <= r_min_y;
                r_box_y1    <= r_max_y;
                r_box_cx    <= w_sum_x[XW:1];
                r_box_cy    <= w_sum_y[YW:1];
                r_box_cnt   <= r_cnt;
                r_box_valid <= (r_cnt >= MIN_CNT);
            end
        end
    end

`ifdef TARGET_BOX_OVERLAY_EN
    logic [XW-1:0] w_d1_x;
    logic [YW-1:0] w_d1_y;
    logic          w_border;

    assign w_d1_x = r_pack_d1[YW +: XW];
    assign w_d1_y = r_pack_d1[0 +: YW];

    // Border is judged on the stage-1 pixel against the currently published box.
    always_comb begin
        w_border = 1'b0;
        if (r_box_valid && en && r_pack_d1[DE_B] &&
            (w_d1_x >= r_box_x0) && (w_d1_x <= r_box_x1) &&
            (w_d1_y >= r_box_y0) && (w_d1_y <= r_box_y1))
            w_border = (w_d1_x == r_box_x0) || (w_d1_x == r_box_x1) ||
                       (w_d1_y == r_box_y0) || (w_d1_y == r_box_y1);
    end

    assign w_pack_s2 = w_border ? {OVERLAY_COLOR, r_pack_d1[RGB_L-1:0]} : r_pack_d1;
`else
    assign w_pack_s2 = r_pack_d1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack_d1 <= '0;
            r_pack_d2 <= '0;
        end else begin
            r_pack_d1 <= i_pack;
            r_pack_d2 <= w_pack_s2;
        end
    end

    assign o_pack     = r_pack_d2;
    assign box_x0     = r_box_x0;
    assign box_x1     = r_box_x1;
    assign box_y0     = r_box_y0;
    assign box_y1     = r_box_y1;
    assign box_cx     = r_box_cx;
    assign box_cy     = r_box_cy;
    assign box_cnt    = r_box_cnt;
    assign box_valid  = r_box_valid;
    assign frame_done = r_frame_done;

endmodule
